seg7_scan_driver: RTL

Parametrised, time-multiplexed driver for a bank of common-anode 7-segment digits. It latches a packed multi-digit nibble value and scans one digit at a time at a programmable refresh rate. Per digit it drives segment, anode and decimal-point outputs, with optional hex glyphs and leading-zero blanking. It sits between datapath result registers (e.g. SDES key/ciphertext) and the board display pins, replacing one static decoder per digit.

---
 rtl/seg7_scan_driver.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexed driver for a bank of common-anode
// 7-segment digits. A shadow register takes new values at any time. The
// display register copies the shadow only at frame wrap, so a frame never
// mixes two values. Segment, anode and decimal-point pins are registered.
module seg7_scan_driver #(
  parameter int unsigned NUM_DIGITS  = 4,
  parameter int unsigned REFRESH_DIV = 50000,
  parameter int unsigned HEX_MODE    = 1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    load,
  input  logic                    enable,
  input  logic                    lz_blank,
  output logic [0:6]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_done
);

  localparam int unsigned CW = $clog2(REFRESH_DIV);
  localparam int unsigned IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CW-1:0]         CNT_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0]         IDX_LAST = IW'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] ONE_HOT  = NUM_DIGITS'(1);

  logic [CW-1:0]           cnt_q, cnt_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] sh_val_q, sh_val_d;
  logic [NUM_DIGITS-1:0]   sh_dp_q, sh_dp_d;
  logic [4*NUM_DIGITS-1:0] disp_val_q, disp_val_d;
  logic [NUM_DIGITS-1:0]   disp_dp_q, disp_dp_d;
  logic [0:6]              seg_q, seg_d;
  logic                    dp_q, dp_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic                    fd_q, fd_d;

  logic                    tick, wrap;
  logic [4*NUM_DIGITS-1:0] val_shift;
  logic [NUM_DIGITS-1:0]   dp_shift;
  logic [3:0]              nib_cur;
  logic                    dp_cur;
  logic                    blank_cur;

  // Glyph lookup, seg[0]=a .. seg[6]=g, 0 = lit.
  function automatic logic [0:6] glyph(input logic [3:0] nib);
    logic [0:6] g;
    g = '1;
    case (nib)
      4'h0: g = 7'b0000001;
      4'h1: g = 7'b1001111;
      4'h2: g = 7'b0010010;
      4'h3: g = 7'b0000110;
      4'h4: g = 7'b1001100;
      4'h5: g = 7'b0100100;
      4'h6: g = 7'b0100000;
      4'h7: g = 7'b0001111;
      4'h8: g = 7'b0000000;
      4'h9: g = 7'b0000100;
      4'hA: g = (HEX_MODE != 0) ? 7'b0001000 : 7'b1111111;
      4'hB: g = (HEX_MODE != 0) ? 7'b1100000 : 7'b1111111;
      4'hC: g = (HEX_MODE != 0) ? 7'b0110001 : 7'b1111111;
      4'hD: g = (HEX_MODE != 0) ? 7'b1000010 : 7'b1111111;
      4'hE: g = (HEX_MODE != 0) ? 7'b0110000 : 7'b1111111;
      4'hF: g = (HEX_MODE != 0) ? 7'b0111000 : 7'b1111111;
      default: g = '1;
    endcase
    return g;
  endfunction

  // Prescaler, digit index, shadow and display register next-state.
  always_comb begin
    tick       = (cnt_q == CNT_LAST);
    wrap       = tick && (idx_q == IDX_LAST);
    cnt_d      = tick ? '0 : cnt_q + 1'b1;
    idx_d      = idx_q;
    sh_val_d   = sh_val_q;
    sh_dp_d    = sh_dp_q;
    disp_val_d = disp_val_q;
    disp_dp_d  = disp_dp_q;
    fd_d       = wrap;
    if (tick) begin
      idx_d = wrap ? '0 : idx_q + 1'b1;
    end
    if (load) begin
      sh_val_d = value;
      sh_dp_d  = dp_in;
    end
    // Display takes the pre-edge shadow, so a load on the wrap edge waits a frame.
    if (wrap) begin
      disp_val_d = sh_val_q;
      disp_dp_d  = sh_dp_q;
    end
  end

  // Digit selection and pin next-state. Shifting the display value down by
  // the current index leaves only this nibble and those above it, so a zero
  // result means the digit is a leading zero.
  always_comb begin
    val_shift = disp_val_q >> {idx_q, 2'b00};
    dp_shift  = disp_dp_q >> idx_q;
    nib_cur   = val_shift[3:0];
    dp_cur    = dp_shift[0];
    blank_cur = lz_blank && (idx_q != '0) && (val_shift == '0);
    seg_d     = '1;
    dp_d      = 1'b1;
    an_d      = '1;
    if (enable) begin
      an_d = ~(ONE_HOT << idx_q);
      if (!blank_cur) begin
        seg_d = glyph(nib_cur);
        dp_d  = ~dp_cur;
      end
    end
  end

  // State and output registers; reset clears everything, including the shadow.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q      <= '0;
      idx_q      <= '0;
      sh_val_q   <= '0;
      sh_dp_q    <= '0;
      disp_val_q <= '0;
      disp_dp_q  <= '0;
      seg_q      <= '1;
      dp_q       <= 1'b1;
      an_q       <= '1;
      fd_q       <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      sh_val_q   <= sh_val_d;
      sh_dp_q    <= sh_dp_d;
      disp_val_q <= disp_val_d;
      disp_dp_q  <= disp_dp_d;
      seg_q      <= seg_d;
      dp_q       <= dp_d;
      an_q       <= an_d;
      fd_q       <= fd_d;
    end
  end

  assign seg        = seg_q;
  assign dp         = dp_q;
  assign an         = an_q;
  assign frame_done = fd_q;

endmodule
